// File: rtl/cpu_alu_pkg.sv
// Shared types for the iterative CPU ALU: opcode and FSM state encodings,
// plus a helper that classifies the iterative (shift) operations.
package cpu_alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SH1ADD = 5'd5,
        ALU_SH2ADD = 5'd6,
        ALU_SH3ADD = 5'd7,
        ALU_SLL    = 5'd8,
        ALU_SRL    = 5'd9,
        ALU_SRA    = 5'd10,
        ALU_SLT    = 5'd11,
        ALU_SLTU   = 5'd12,
        ALU_EQ     = 5'd13,
        ALU_NE     = 5'd14,
        ALU_GE     = 5'd15,
        ALU_GEU    = 5'd16
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    // Shifts are the only operations that run over several cycles.
    function automatic logic is_shift_op(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/cpu_alu_shift_step.sv
// Combinational single-iteration shifter: shifts data by amt (at most
// SHIFT_STEP bits) left or right, filling vacated bits on the right shift
// with the supplied fill bit (sign for SRA, zero for SRL).
module cpu_alu_shift_step
    import cpu_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    localparam int AMT_W     = $clog2(SHIFT_STEP) + 1
) (
    input  logic [XLEN-1:0]  data,
    input  logic             dir_right,
    input  logic             fill,
    input  logic [AMT_W-1:0] amt,
    output logic [XLEN-1:0]  result
);

    logic [2*XLEN-1:0] ext_shr;

    // Right shifts go through a double-width word so the fill bit enters from the top.
    always_comb begin
        ext_shr = {{XLEN{fill}}, data} >> amt;
        if (dir_right) begin
            result = ext_shr[XLEN-1:0];
        end else begin
            result = data << amt;
        end
    end

endmodule

// File: rtl/cpu_alu_iterative.sv
// Multi-cycle CPU ALU with request/accept handshake. Non-shift operations
// complete in one cycle; shifts iterate SHIFT_STEP bits per cycle, reusing
// the result register as the shift register. The result is held in DONE
// until the consumer accepts it; accept plus request starts the next op
// with no idle cycle.
module cpu_alu_iterative
    import cpu_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    localparam int SHAMT_W   = $clog2(XLEN)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_request,
    input  alu_op_t         i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_accept,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_compare_result
);

    localparam int AMT_W = $clog2(SHIFT_STEP) + 1;
    localparam logic [SHAMT_W:0] STEP_AMT = (SHAMT_W + 1)'(SHIFT_STEP);

    alu_state_t         state;
    alu_state_t         state_nxt;
    logic [XLEN-1:0]    result_q;
    logic               cmp_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               dir_right_q;
    logic               fill_q;

    logic               start;
    logic               load_alu;
    logic               load_shift;
    logic               step_en;
    logic [XLEN-1:0]    alu_res;
    logic               alu_cmp;
    logic [SHAMT_W:0]   step_amt;
    logic [SHAMT_W-1:0] cnt_nxt;
    logic [XLEN-1:0]    shift_res;
    logic [SHAMT_W-1:0] req_shamt;

    assign req_shamt = i_op2[SHAMT_W-1:0];

    // Single-cycle operations; shift opcodes only land here with a zero amount.
    always_comb begin
        alu_res = '0;
        alu_cmp = 1'b0;
        case (i_op)
            ALU_ADD:    alu_res = i_op1 + i_op2;
            ALU_SUB:    alu_res = i_op1 - i_op2;
            ALU_AND:    alu_res = i_op1 & i_op2;
            ALU_OR:     alu_res = i_op1 | i_op2;
            ALU_XOR:    alu_res = i_op1 ^ i_op2;
            ALU_SH1ADD: alu_res = (i_op1 << 1) + i_op2;
            ALU_SH2ADD: alu_res = (i_op1 << 2) + i_op2;
            ALU_SH3ADD: alu_res = (i_op1 << 3) + i_op2;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:    alu_res = i_op1;
            ALU_SLT:    alu_cmp = $signed(i_op1) < $signed(i_op2);
            ALU_SLTU:   alu_cmp = i_op1 < i_op2;
            ALU_EQ:     alu_cmp = i_op1 == i_op2;
            ALU_NE:     alu_cmp = i_op1 != i_op2;
            ALU_GE:     alu_cmp = $signed(i_op1) >= $signed(i_op2);
            ALU_GEU:    alu_cmp = i_op1 >= i_op2;
            default:    ;
        endcase
    end

    // Per-iteration shift amount is the smaller of SHIFT_STEP and what remains.
    always_comb begin
        step_amt = ({1'b0, cnt_q} >= STEP_AMT) ? STEP_AMT : {1'b0, cnt_q};
        cnt_nxt  = SHAMT_W'({1'b0, cnt_q} - step_amt);
    end

    cpu_alu_shift_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .data      (result_q),
        .dir_right (dir_right_q),
        .fill      (fill_q),
        .amt       (step_amt[AMT_W-1:0]),
        .result    (shift_res)
    );

    // Next-state and datapath load controls; a start is shared by IDLE and accepted DONE.
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        load_alu   = 1'b0;
        load_shift = 1'b0;
        step_en    = 1'b0;
        case (state)
            IDLE: start = i_request;
            SHIFT: begin
                step_en = 1'b1;
                if (cnt_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_accept) begin
                    state_nxt = IDLE;
                    start     = i_request;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            if (is_shift_op(i_op) && (req_shamt != '0)) begin
                state_nxt  = SHIFT;
                load_shift = 1'b1;
            end else begin
                state_nxt = DONE;
                load_alu  = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result/shift register, remaining-shift counter and latched shift controls.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            result_q    <= '0;
            cmp_q       <= 1'b0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
            fill_q      <= 1'b0;
        end else if (load_alu) begin
            result_q <= alu_res;
            cmp_q    <= alu_cmp;
            cnt_q    <= '0;
        end else if (load_shift) begin
            result_q    <= i_op1;
            cmp_q       <= 1'b0;
            cnt_q       <= req_shamt;
            dir_right_q <= (i_op != ALU_SLL);
            fill_q      <= (i_op == ALU_SRA) & i_op1[XLEN-1];
        end else if (step_en) begin
            result_q <= shift_res;
            cnt_q    <= cnt_nxt;
        end
    end

    assign o_busy           = (state != IDLE) && !((state == DONE) && i_accept);
    assign o_valid          = (state == DONE);
    assign o_result         = result_q;
    assign o_compare_result = cmp_q;

endmodule

// File: tb/tb_cpu_alu_iterative.sv
// Bench for cpu_alu_iterative: a 32-bit/step-1 instance checked every cycle
// against a transaction-level model, plus a 32-bit/step-4 and a
// 64-bit/single-iteration instance driven with directed vectors.
module tb_cpu_alu_iterative;
    import cpu_alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: XLEN=32, SHIFT_STEP=1, model-checked
    logic        req, acc;
    alu_op_t     op;
    logic [31:0] op1, op2;
    logic        busy, valid, cmp;
    logic [31:0] res;

    cpu_alu_iterative #(.XLEN(32), .SHIFT_STEP(1)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_request(req), .i_op(op),
        .i_op1(op1), .i_op2(op2), .i_accept(acc),
        .o_busy(busy), .o_valid(valid), .o_result(res), .o_compare_result(cmp)
    );

    // Instance B: XLEN=32, SHIFT_STEP=4
    logic        b_req, b_acc;
    alu_op_t     b_op;
    logic [31:0] b_op1, b_op2;
    logic        b_busy, b_valid, b_cmp;
    logic [31:0] b_res;

    cpu_alu_iterative #(.XLEN(32), .SHIFT_STEP(4)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_request(b_req), .i_op(b_op),
        .i_op1(b_op1), .i_op2(b_op2), .i_accept(b_acc),
        .o_busy(b_busy), .o_valid(b_valid), .o_result(b_res), .o_compare_result(b_cmp)
    );

    // Instance C: XLEN=64, SHIFT_STEP=64
    logic        c_req, c_acc;
    alu_op_t     c_op;
    logic [63:0] c_op1, c_op2;
    logic        c_busy, c_valid, c_cmp;
    logic [63:0] c_res;

    cpu_alu_iterative #(.XLEN(64), .SHIFT_STEP(64)) dut_c (
        .i_clock(clk), .i_reset(rst), .i_request(c_req), .i_op(c_op),
        .i_op1(c_op1), .i_op2(c_op2), .i_accept(c_acc),
        .o_busy(c_busy), .o_valid(c_valid), .o_result(c_res), .o_compare_result(c_cmp)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: result and compare bit from the operation definitions.
    function automatic logic [32:0] ref_alu(input alu_op_t f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c;
        int          sh;
        r  = 32'd0;
        c  = 1'b0;
        sh = int'(b[4:0]);
        case (f)
            ALU_ADD:    r = a + b;
            ALU_SUB:    r = a - b;
            ALU_AND:    r = a & b;
            ALU_OR:     r = a | b;
            ALU_XOR:    r = a ^ b;
            ALU_SH1ADD: r = a * 32'd2 + b;
            ALU_SH2ADD: r = a * 32'd4 + b;
            ALU_SH3ADD: r = a * 32'd8 + b;
            ALU_SLL:    r = a << sh;
            ALU_SRL:    r = a >> sh;
            ALU_SRA:    r = $signed(a) >>> sh;
            ALU_SLT:    c = $signed(a) < $signed(b);
            ALU_SLTU:   c = a < b;
            ALU_EQ:     c = a == b;
            ALU_NE:     c = a != b;
            ALU_GE:     c = $signed(a) >= $signed(b);
            ALU_GEU:    c = a >= b;
            default:    ;
        endcase
        return {c, r};
    endfunction

    function automatic int ref_lat(input alu_op_t f, input logic [31:0] b);
        if (f == ALU_SLL || f == ALU_SRL || f == ALU_SRA) return 1 + int'(b[4:0]);
        return 1;
    endfunction

    // Transaction model of instance A: one op in flight, countdown to valid.
    logic        m_valid = 1'b0, m_pend = 1'b0, m_cmp = 1'b0;
    logic [31:0] m_res = 32'd0;
    int          m_left = 0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0; m_pend = 1'b0; m_left = 0; m_res = 32'd0; m_cmp = 1'b0;
        end else begin
            if (m_valid && acc) m_valid = 1'b0;
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin m_pend = 1'b0; m_valid = 1'b1; end
            end else if (!m_valid && req) begin
                {m_cmp, m_res} = ref_alu(op, op1, op2);
                m_left = ref_lat(op, op2) - 1;
                if (m_left == 0) m_valid = 1'b1;
                else m_pend = 1'b1;
            end
        end
    end

    // Every-cycle comparison of instance A against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 64'(valid), 64'(m_valid));
            chk("model_busy", 64'(busy), 64'((m_pend || m_valid) && !(m_valid && acc)));
            if (m_valid) begin
                chk("model_result", 64'(res), 64'(m_res));
                chk("model_cmp", 64'(cmp), 64'(m_cmp));
            end
        end
    end

    task automatic run_a(input alu_op_t f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_c, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        req = 1'b1; op = f; op1 = a; op2 = b;
        @(posedge clk); #1;
        req = 1'b0; op = ALU_XOR; op1 = ~a; op2 = ~b;
        lat = 1;
        while (!valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("a_latency", 64'(lat), 64'(exp_lat));
        chk("a_result", 64'(res), 64'(exp_r));
        chk("a_cmp", 64'(cmp), 64'(exp_c));
        @(posedge clk); #1;
        chk("a_hold", 64'(res), 64'(exp_r));
        acc = 1'b1;
        @(posedge clk); #1;
        acc = 1'b0;
        chk("a_retired", 64'(valid), 64'd0);
    endtask

    task automatic run_b(input alu_op_t f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        b_req = 1'b1; b_op = f; b_op1 = a; b_op2 = b;
        @(posedge clk); #1;
        b_req = 1'b0; b_op1 = 32'd0;
        lat = 1;
        while (!b_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("b_latency", 64'(lat), 64'(exp_lat));
        chk("b_result", 64'(b_res), 64'(exp_r));
        b_acc = 1'b1;
        @(posedge clk); #1;
        b_acc = 1'b0;
    endtask

    task automatic run_c(input alu_op_t f, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_r, input logic exp_c, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        c_req = 1'b1; c_op = f; c_op1 = a; c_op2 = b;
        @(posedge clk); #1;
        c_req = 1'b0; c_op1 = 64'd0;
        lat = 1;
        while (!c_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("c_latency", 64'(lat), 64'(exp_lat));
        chk("c_result", c_res, exp_r);
        chk("c_cmp", 64'(c_cmp), 64'(exp_c));
        c_acc = 1'b1;
        @(posedge clk); #1;
        c_acc = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        req = 1'b0; acc = 1'b0; op = ALU_ADD; op1 = 32'd0; op2 = 32'd0;
        b_req = 1'b0; b_acc = 1'b0; b_op = ALU_ADD; b_op1 = 32'd0; b_op2 = 32'd0;
        c_req = 1'b0; c_acc = 1'b0; c_op = ALU_ADD; c_op1 = 64'd0; c_op2 = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_result", 64'(res), 64'd0);
        chk("rst_cmp", 64'(cmp), 64'd0);
        chk_en = 1'b1;

        // Single-cycle ops and compares with hand-computed results
        run_a(ALU_ADD,    32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1);
        run_a(ALU_SUB,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1);
        run_a(ALU_AND,    32'hF0F0FFFF, 32'h0FF00F0F, 32'h00F00F0F, 1'b0, 1);
        run_a(ALU_OR,     32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1);
        run_a(ALU_SH2ADD, 32'h00000003, 32'h00000001, 32'h0000000D, 1'b0, 1);
        run_a(ALU_SH3ADD, 32'h20000001, 32'h00000001, 32'h00000009, 1'b0, 1);
        run_a(ALU_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1);
        run_a(ALU_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
        run_a(ALU_EQ,     32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1);
        run_a(ALU_NE,     32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1);
        run_a(ALU_GE,     32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1);
        run_a(ALU_GEU,    32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);
        run_a(alu_op_t'(5'd31), 32'h11111111, 32'h22222222, 32'h00000000, 1'b0, 1);

        // Iterative shifts, including amount 0, maximum amount and upper op2 bits ignored
        run_a(ALU_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 5);
        run_a(ALU_SRA, 32'h70000000, 32'h00000024, 32'h07000000, 1'b0, 5);
        run_a(ALU_SRL, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 32);
        run_a(ALU_SLL, 32'h000000AB, 32'h00000000, 32'h000000AB, 1'b0, 1);
        run_a(ALU_SLL, 32'h00000003, 32'h00000003, 32'h00000018, 1'b0, 4);

        // Back-to-back: accept and request together, no idle cycle
        @(posedge clk); #1;
        req = 1'b1; op = ALU_ADD; op1 = 32'd10; op2 = 32'd20;
        @(posedge clk); #1;
        req = 1'b0;
        chk("b2b_first_valid", 64'(valid), 64'd1);
        chk("b2b_first_result", 64'(res), 64'd30);
        chk("b2b_busy_on_accept", 64'(busy), 64'd1);
        acc = 1'b1; req = 1'b1; op = ALU_XOR; op1 = 32'hF0F0F0F0; op2 = 32'hFFFF0000;
        #1;
        chk("b2b_busy_low", 64'(busy), 64'd0);
        @(posedge clk); #1;
        acc = 1'b0; req = 1'b0;
        chk("b2b_second_valid", 64'(valid), 64'd1);
        chk("b2b_second_result", 64'(res), 64'h0F0FF0F0);
        acc = 1'b1;
        @(posedge clk); #1;
        acc = 1'b0;

        // A request during an active shift is ignored
        @(posedge clk); #1;
        req = 1'b1; op = ALU_SLL; op1 = 32'd1; op2 = 32'd8;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req = 1'b1; op = ALU_ADD; op1 = 32'd2; op2 = 32'd3;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 4;
        while (!valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("ignore_latency", 64'(lat), 64'd9);
        chk("ignore_result", 64'(res), 64'h00000100);
        acc = 1'b1;
        @(posedge clk); #1;
        acc = 1'b0;

        // Reset in the middle of a long shift aborts it
        @(posedge clk); #1;
        req = 1'b1; op = ALU_SLL; op1 = 32'd1; op2 = 32'd31;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_result", 64'(res), 64'd0);
        chk("abort_cmp", 64'(cmp), 64'd0);
        run_a(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        // Four-bit-per-cycle shifter
        run_b(ALU_SRA, 32'h80000000, 32'd4,  32'hF8000000, 2);
        run_b(ALU_SRL, 32'h80000000, 32'd31, 32'h00000001, 9);
        run_b(ALU_SLL, 32'h00000001, 32'd5,  32'h00000020, 3);

        // 64-bit, single-iteration shifter
        run_c(ALU_SH3ADD, 64'h1000000000000000, 64'h8, 64'h8000000000000008, 1'b0, 1);
        run_c(ALU_SRA,    64'h8000000000000000, 64'd63, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2);
        run_c(ALU_SUB,    64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1);
        run_c(ALU_SLT,    64'h8000000000000000, 64'h1, 64'h0, 1'b1, 1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
